// File: rtl/pwm_capture.sv
// PWM period / high-time capture with stuck-signal detection.
// Optional 3-sample glitch filter when PWM_CAPTURE_FILTER_EN is defined.
module pwm_capture #(
   parameter int CTR_LEN = 8,
   parameter int TIMEOUT = (2 ** CTR_LEN) - 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pwm_in,
   output logic [CTR_LEN-1:0] period,
   output logic [CTR_LEN-1:0] high_time,
   output logic               valid,
   output logic               stuck,
   output logic               stuck_level
);

   typedef enum logic [1:0] {
      SEEK  = 2'd0,
      HIGH  = 2'd1,
      LOW   = 2'd2,
      STUCK = 2'd3
   } state_t;

   localparam logic [CTR_LEN-1:0] TIMEOUT_C = CTR_LEN'(TIMEOUT);
   localparam logic [CTR_LEN-1:0] ONE_C     = CTR_LEN'(1);

   logic [1:0]         r_sync;
   logic               r_s_prev;
   logic               w_s;
   logic               w_rise;
   logic               w_fall;
   logic               w_timeout;

   state_t             r_state;
   state_t             w_next;
   logic               w_load;
   logic               w_publish;
   logic               w_inc_per;
   logic               w_inc_high;

   logic [CTR_LEN-1:0] r_per_cnt;
   logic [CTR_LEN-1:0] r_high_cnt;
   logic [CTR_LEN-1:0] r_period;
   logic [CTR_LEN-1:0] r_high_time;
   logic               r_valid;
   logic               r_stuck;
   logic               r_stuck_level;

   // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync   <= '0;
         r_s_prev <= 1'b0;
      end else begin
         r_sync   <= {r_sync[0], pwm_in};
         r_s_prev <= w_s;
      end
   end

`ifdef PWM_CAPTURE_FILTER_EN
   // s moves only when the current and two previous synchronized samples agree.
   logic [1:0] r_hist;
   logic       r_filt;
   logic       w_all1;
   logic       w_all0;

   assign w_all1 = &{r_hist, r_sync[1]};
   assign w_all0 = ~|{r_hist, r_sync[1]};
   assign w_s    = w_all1 | (r_filt & ~w_all0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hist <= '0;
         r_filt <= 1'b0;
      end else begin
         r_hist <= {r_hist[0], r_sync[1]};
         r_filt <= w_s;
      end
   end
`else
   assign w_s = r_sync[1];
`endif

   assign w_rise    = w_s & ~r_s_prev;
   assign w_fall    = ~w_s & r_s_prev;
   assign w_timeout = (r_per_cnt == TIMEOUT_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SEEK;
      end else begin
         r_state <= w_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_publish  = 1'b0;
      w_inc_per  = 1'b0;
      w_inc_high = 1'b0;
      unique case (r_state)
         SEEK: begin
            if (w_rise) begin
               w_next = HIGH;
               w_load = 1'b1;
            end
         end
         HIGH: begin
            if (w_timeout) begin
               w_next = STUCK;
            end else if (w_fall) begin
               w_next    = LOW;
               w_inc_per = 1'b1;
            end else begin
               w_inc_per  = 1'b1;
               w_inc_high = 1'b1;
            end
         end
         LOW: begin
            // A rising edge on the timeout cycle still completes the period.
            if (w_rise) begin
               w_next    = HIGH;
               w_load    = 1'b1;
               w_publish = 1'b1;
            end else if (w_timeout) begin
               w_next = STUCK;
            end else begin
               w_inc_per = 1'b1;
            end
         end
         STUCK: begin
            if (w_rise) begin
               w_next = HIGH;
               w_load = 1'b1;
            end
         end
         default: w_next = SEEK;
      endcase
   end

   // The rising-edge cycle counts as cycle 1 of the new period and high phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_per_cnt  <= '0;
         r_high_cnt <= '0;
      end else if (w_load) begin
         r_per_cnt  <= ONE_C;
         r_high_cnt <= ONE_C;
      end else begin
         if (w_inc_per) begin
            r_per_cnt <= r_per_cnt + ONE_C;
         end
         if (w_inc_high) begin
            r_high_cnt <= r_high_cnt + ONE_C;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_period      <= '0;
         r_high_time   <= '0;
         r_valid       <= 1'b0;
         r_stuck       <= 1'b0;
         r_stuck_level <= 1'b0;
      end else begin
         r_valid <= w_publish;
         if (w_publish) begin
            r_period    <= r_per_cnt;
            r_high_time <= r_high_cnt;
         end
         r_stuck <= (w_next == STUCK);
         if (w_next == STUCK) begin
            r_stuck_level <= w_s;
         end
      end
   end

   assign period      = r_period;
   assign high_time   = r_high_time;
   assign valid       = r_valid;
   assign stuck       = r_stuck;
   assign stuck_level = r_stuck_level;

endmodule
